// File: rtl/axi4_burst_master_if.sv
// rtl/axi4_burst_master_if.sv - AXI4 master-side bus bundle for axi4_burst_master
//
// Groups the five AXI4 channels (AW, W, B, AR, R) driven by axi4_burst_master.
// master modport: the burst master (drives AW/W/AR payloads, b_ready, r_ready).
// slave modport:  the AXI4 slave port it talks to.
interface axi4_burst_master_if #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 32
);
    logic                      aw_valid;
    logic                      aw_ready;
    logic [ADDR_WIDTH-1:0]     aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;

    logic                      w_valid;
    logic                      w_ready;
    logic [DATA_WIDTH-1:0]     w_data;
    logic [DATA_WIDTH/8-1:0]   w_strb;
    logic                      w_last;

    logic                      b_valid;
    logic                      b_ready;
    logic [1:0]                b_resp;

    logic                      ar_valid;
    logic                      ar_ready;
    logic [ADDR_WIDTH-1:0]     ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;

    logic                      r_valid;
    logic                      r_ready;
    logic [DATA_WIDTH-1:0]     r_data;
    logic [1:0]                r_resp;
    logic                      r_last;

    modport master (
        output aw_valid, aw_addr, aw_len, aw_size, aw_burst,
        input  aw_ready,
        output w_valid, w_data, w_strb, w_last,
        input  w_ready,
        input  b_valid, b_resp,
        output b_ready,
        output ar_valid, ar_addr, ar_len, ar_size, ar_burst,
        input  ar_ready,
        input  r_valid, r_data, r_resp, r_last,
        output r_ready
    );

    modport slave (
        input  aw_valid, aw_addr, aw_len, aw_size, aw_burst,
        output aw_ready,
        input  w_valid, w_data, w_strb, w_last,
        output w_ready,
        output b_valid, b_resp,
        input  b_ready,
        input  ar_valid, ar_addr, ar_len, ar_size, ar_burst,
        output ar_ready,
        output r_valid, r_data, r_resp, r_last,
        input  r_ready
    );
endinterface

// File: rtl/axi4_burst_master.sv
// rtl/axi4_burst_master.sv - byte-length command to AXI4 INCR burst converter
//
// Ports:
//   clk, reset (async assert, active low)
//   cmd_valid/cmd_ready, cmd_write, cmd_addr, cmd_size   : command in
//   wdata_valid/wdata_ready, wdata_payload_fragment/_last : write beats in
//   rdata_valid/rdata_ready, rdata_payload_fragment/_last : read beats out
//   rsp_valid, rsp_payload                                : one response per command
//   masterAxi                                             : AXI4 master channels
module axi4_burst_master #(
    parameter int DATA_WIDTH    = 128,
    parameter int ADDR_WIDTH    = 32,
    parameter int MAX_BURST_LEN = 256,
    parameter int BOUNDARY      = 4096
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [31:0]             cmd_size,
    input  logic                    wdata_valid,
    output logic                    wdata_ready,
    input  logic [DATA_WIDTH-1:0]   wdata_payload_fragment,
    input  logic                    wdata_payload_last,
    output logic                    rdata_valid,
    input  logic                    rdata_ready,
    output logic [DATA_WIDTH-1:0]   rdata_payload_fragment,
    output logic                    rdata_payload_last,
    output logic                    rsp_valid,
    output logic [1:0]              rsp_payload,
    axi4_burst_master_if.master     masterAxi
);
    localparam int BYTES    = DATA_WIDTH / 8;
    localparam int SIZE_LOG = $clog2(BYTES);
    localparam int BOFF_W   = $clog2(BOUNDARY);

    typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, RSP} state_t;

    state_t                 state, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [31:0]            remaining_q;    // beats not yet covered by an issued burst
    logic [SIZE_LOG-1:0]    last_bytes_q;
    logic [8:0]             burst_len_q;
    logic [8:0]             beat_cnt_q;
    logic [1:0]             resp_acc_q;

    logic [32:0]            beats_calc;
    logic [32:0]            room;
    logic [32:0]            len_calc;
    logic [8:0]             cur_len;
    logic                   burst_last;
    logic                   cmd_last;
    logic                   ax_fire;
    logic [BYTES-1:0]       strb_partial;
    logic                   unused_ok;

    assign beats_calc   = (33'(cmd_size) + 33'(BYTES - 1)) >> SIZE_LOG;
    assign room         = (33'(BOUNDARY) - 33'(addr_q[BOFF_W-1:0])) >> SIZE_LOG;
    assign strb_partial = ~({BYTES{1'b1}} << last_bytes_q);

    // Burst length: bounded by what is left, by the AXI limit and by the boundary.
    always_comb begin
        len_calc = 33'(remaining_q);
        if (33'(MAX_BURST_LEN) < len_calc) len_calc = 33'(MAX_BURST_LEN);
        if (room < len_calc) len_calc = room;
    end
    assign cur_len = len_calc[8:0];

    assign burst_last = (beat_cnt_q == burst_len_q - 9'd1);
    // remaining_q is already decremented when the burst is issued, so zero here
    // means this burst finishes the command.
    assign cmd_last   = burst_last && (remaining_q == 32'd0);
    assign ax_fire    = (state == AW && masterAxi.aw_ready) || (state == AR && masterAxi.ar_ready);

    assign unused_ok  = ^{wdata_payload_last, masterAxi.r_last, len_calc[32:9], beats_calc[32]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q       <= '0;
            remaining_q  <= '0;
            last_bytes_q <= '0;
            burst_len_q  <= '0;
            beat_cnt_q   <= '0;
            resp_acc_q   <= '0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    addr_q       <= cmd_addr;
                    remaining_q  <= beats_calc[31:0];
                    last_bytes_q <= cmd_size[SIZE_LOG-1:0];
                    resp_acc_q   <= '0;
                end
                AW, AR: if (ax_fire) begin
                    burst_len_q <= cur_len;
                    beat_cnt_q  <= '0;
                    remaining_q <= remaining_q - 32'(cur_len);
                    addr_q      <= addr_q + (ADDR_WIDTH'(cur_len) << SIZE_LOG);
                end
                W: if (wdata_valid && masterAxi.w_ready) beat_cnt_q <= beat_cnt_q + 9'd1;
                B: if (masterAxi.b_valid && masterAxi.b_resp > resp_acc_q)
                    resp_acc_q <= masterAxi.b_resp;
                R: if (masterAxi.r_valid && rdata_ready) begin
                    beat_cnt_q <= beat_cnt_q + 9'd1;
                    if (masterAxi.r_resp > resp_acc_q) resp_acc_q <= masterAxi.r_resp;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d                = state;
        cmd_ready              = 1'b0;
        wdata_ready            = 1'b0;
        rdata_valid            = 1'b0;
        rdata_payload_fragment = masterAxi.r_data;
        rdata_payload_last     = 1'b0;
        rsp_valid              = 1'b0;
        rsp_payload            = 2'b00;
        masterAxi.aw_valid     = 1'b0;
        masterAxi.aw_addr      = addr_q;
        masterAxi.aw_len       = 8'(cur_len - 9'd1);
        masterAxi.aw_size      = 3'(SIZE_LOG);
        masterAxi.aw_burst     = 2'b01;
        masterAxi.w_valid      = 1'b0;
        masterAxi.w_data       = wdata_payload_fragment;
        masterAxi.w_strb       = (cmd_last && last_bytes_q != '0) ? strb_partial : {BYTES{1'b1}};
        masterAxi.w_last       = 1'b0;
        masterAxi.b_ready      = 1'b0;
        masterAxi.ar_valid     = 1'b0;
        masterAxi.ar_addr      = addr_q;
        masterAxi.ar_len       = 8'(cur_len - 9'd1);
        masterAxi.ar_size      = 3'(SIZE_LOG);
        masterAxi.ar_burst     = 2'b01;
        masterAxi.r_ready      = 1'b0;

        case (state)
            IDLE: begin
                // Gated by reset so cmd_ready is low while reset is held.
                cmd_ready = reset;
                if (cmd_valid) begin
                    if (cmd_size == 32'd0) state_d = RSP;
                    else if (cmd_write)    state_d = AW;
                    else                   state_d = AR;
                end
            end
            AW: begin
                masterAxi.aw_valid = 1'b1;
                if (masterAxi.aw_ready) state_d = W;
            end
            W: begin
                masterAxi.w_valid = wdata_valid;
                masterAxi.w_last  = burst_last;
                wdata_ready       = masterAxi.w_ready;
                if (wdata_valid && masterAxi.w_ready && burst_last) state_d = B;
            end
            B: begin
                masterAxi.b_ready = 1'b1;
                if (masterAxi.b_valid) state_d = (remaining_q == 32'd0) ? RSP : AW;
            end
            AR: begin
                masterAxi.ar_valid = 1'b1;
                if (masterAxi.ar_ready) state_d = R;
            end
            R: begin
                rdata_valid        = masterAxi.r_valid;
                masterAxi.r_ready  = rdata_ready;
                // Command-level last, independent of the slave's per-burst r_last.
                rdata_payload_last = cmd_last;
                if (masterAxi.r_valid && rdata_ready && burst_last)
                    state_d = (remaining_q == 32'd0) ? RSP : AR;
            end
            RSP: begin
                rsp_valid   = 1'b1;
                rsp_payload = resp_acc_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_axi4_burst_master.sv
// tb/tb_axi4_burst_master.sv - directed self-checking bench for axi4_burst_master
module tb_axi4_burst_master;
    localparam int DW  = 128;
    localparam int AWD = 32;

    typedef struct { logic [31:0] addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst; } ax_t;
    typedef struct { logic [15:0] strb; logic last; logic [127:0] data; } wb_t;
    typedef struct { logic [127:0] data; logic last; } rb_t;
    typedef struct { logic [1:0] payload; int cyc; } rsp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             cmd_valid, cmd_ready, cmd_write;
    logic [AWD-1:0]   cmd_addr;
    logic [31:0]      cmd_size;
    logic             wdata_valid, wdata_ready, wdata_payload_last;
    logic [DW-1:0]    wdata_payload_fragment;
    logic             rdata_valid, rdata_ready, rdata_payload_last;
    logic [DW-1:0]    rdata_payload_fragment;
    logic             rsp_valid;
    logic [1:0]       rsp_payload;

    axi4_burst_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AWD)) axi ();

    axi4_burst_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AWD), .MAX_BURST_LEN(4), .BOUNDARY(4096)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .wdata_payload_fragment(wdata_payload_fragment), .wdata_payload_last(wdata_payload_last),
        .rdata_valid(rdata_valid), .rdata_ready(rdata_ready),
        .rdata_payload_fragment(rdata_payload_fragment), .rdata_payload_last(rdata_payload_last),
        .rsp_valid(rsp_valid), .rsp_payload(rsp_payload),
        .masterAxi(axi.master)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    ax_t  aw_q[$];
    ax_t  ar_q[$];
    wb_t  w_q[$];
    rb_t  rd_q[$];
    rsp_t rsp_q[$];
    int   valid_cnt = 0;
    int   b_total = 0;
    int   r_total = 0;
    int   err_idx = -1;
    logic wsrc_en = 1'b0;
    logic rd_toggle = 1'b0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave model and stream source/sink: drive at negedge, sample 1 time unit later.
    initial begin : bus
        logic b_pending;
        int   r_left;
        b_pending = 1'b0;
        r_left = 0;
        axi.aw_ready = 1'b0; axi.ar_ready = 1'b0; axi.w_ready = 1'b0;
        axi.b_valid = 1'b0; axi.b_resp = 2'b00;
        axi.r_valid = 1'b0; axi.r_data = '0; axi.r_resp = 2'b00; axi.r_last = 1'b0;
        wdata_valid = 1'b0; wdata_payload_fragment = '0; wdata_payload_last = 1'b0;
        rdata_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (!reset) begin
                b_pending = 1'b0;
                r_left = 0;
            end
            axi.aw_ready = 1'b1;
            axi.ar_ready = 1'b1;
            axi.w_ready  = 1'b1;
            axi.b_valid  = b_pending;
            axi.b_resp   = (b_total == err_idx) ? 2'b10 : 2'b00;
            axi.r_valid  = (r_left > 0);
            axi.r_data   = {4{32'h1000_0000 + 32'(r_total)}};
            axi.r_last   = (r_left == 1);
            axi.r_resp   = 2'b00;
            wdata_valid  = wsrc_en;
            wdata_payload_fragment = {4{32'hA000_0000 + 32'(w_q.size())}};
            rdata_ready  = rd_toggle ? ~rdata_ready : 1'b1;
            #1;
            if (axi.aw_valid || axi.w_valid || axi.ar_valid) valid_cnt++;
            if (axi.aw_valid && axi.aw_ready)
                aw_q.push_back('{axi.aw_addr, axi.aw_len, axi.aw_size, axi.aw_burst});
            if (axi.ar_valid && axi.ar_ready) begin
                ar_q.push_back('{axi.ar_addr, axi.ar_len, axi.ar_size, axi.ar_burst});
                r_left = int'(axi.ar_len) + 1;
            end
            if (axi.w_valid && axi.w_ready) begin
                w_q.push_back('{axi.w_strb, axi.w_last, axi.w_data});
                if (axi.w_last) b_pending = 1'b1;
            end
            if (axi.b_valid && axi.b_ready) begin
                b_pending = 1'b0;
                b_total++;
            end
            if (rdata_valid && rdata_ready)
                rd_q.push_back('{rdata_payload_fragment, rdata_payload_last});
            if (axi.r_valid && axi.r_ready) begin
                r_total++;
                r_left--;
            end
            if (rsp_valid) rsp_q.push_back('{rsp_payload, cyc});
        end
    end

    task automatic send_cmd(input logic w, input logic [31:0] addr, input logic [31:0] size,
                            output int hs_cyc);
        int t;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = addr; cmd_size = size;
        #1;
        t = 0;
        while (!cmd_ready && t < 100) begin
            @(negedge clk); #1; t++;
        end
        chk("cmd_accept", 128'(cmd_ready), 128'(1));
        hs_cyc = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n0);
        int t;
        t = 0;
        while (rsp_q.size() <= n0 && t < 400) begin
            @(negedge clk); #2; t++;
        end
        repeat (3) @(negedge clk);
        #2;
        chk("rsp_count", 128'(rsp_q.size() - n0), 128'(1));
    endtask

    initial begin : main
        int naw, nar, nw, nrd, nrs, nb, vc, hs, t;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_cmd_ready",   128'(cmd_ready),     128'(0));
        chk("rst_aw_valid",    128'(axi.aw_valid),  128'(0));
        chk("rst_w_valid",     128'(axi.w_valid),   128'(0));
        chk("rst_ar_valid",    128'(axi.ar_valid),  128'(0));
        chk("rst_rsp_valid",   128'(rsp_valid),     128'(0));
        chk("rst_rdata_valid", 128'(rdata_valid),   128'(0));
        chk("rst_rsp_payload", 128'(rsp_payload),   128'(0));
        @(negedge clk);
        reset = 1'b1;
        wsrc_en = 1'b1;

        // 64 B write @0x1000: one burst of 4 full beats
        naw = aw_q.size(); nw = w_q.size(); nrs = rsp_q.size();
        send_cmd(1'b1, 32'h1000, 32'd64, hs);
        wait_rsp(nrs);
        chk("t1_aw_cnt",   128'(aw_q.size() - naw), 128'(1));
        chk("t1_aw_addr",  128'(aw_q[naw].addr),  128'h1000);
        chk("t1_aw_len",   128'(aw_q[naw].len),   128'(3));
        chk("t1_aw_size",  128'(aw_q[naw].size),  128'(4));
        chk("t1_aw_burst", 128'(aw_q[naw].burst), 128'(1));
        chk("t1_w_cnt",    128'(w_q.size() - nw), 128'(4));
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1_w%0d_strb", i), 128'(w_q[nw+i].strb), 128'hFFFF);
            chk($sformatf("t1_w%0d_last", i), 128'(w_q[nw+i].last), 128'(i == 3));
            chk($sformatf("t1_w%0d_data", i), w_q[nw+i].data, {4{32'hA000_0000 + 32'(nw + i)}});
        end
        chk("t1_rsp", 128'(rsp_q[nrs].payload), 128'(0));

        // 40 B write @0x2000: 3 beats, last one half strobed
        naw = aw_q.size(); nw = w_q.size(); nrs = rsp_q.size();
        send_cmd(1'b1, 32'h2000, 32'd40, hs);
        wait_rsp(nrs);
        chk("t2_aw_cnt",  128'(aw_q.size() - naw), 128'(1));
        chk("t2_aw_addr", 128'(aw_q[naw].addr), 128'h2000);
        chk("t2_aw_len",  128'(aw_q[naw].len),  128'(2));
        chk("t2_w_cnt",   128'(w_q.size() - nw), 128'(3));
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t2_w%0d_strb", i), 128'(w_q[nw+i].strb), (i == 2) ? 128'h00FF : 128'hFFFF);
            chk($sformatf("t2_w%0d_last", i), 128'(w_q[nw+i].last), 128'(i == 2));
        end
        chk("t2_rsp", 128'(rsp_q[nrs].payload), 128'(0));

        // 48 B read @0x0FF0: split at the 4 KiB boundary into 1 + 2 beats
        nar = ar_q.size(); nrd = rd_q.size(); nrs = rsp_q.size();
        send_cmd(1'b0, 32'h0FF0, 32'd48, hs);
        wait_rsp(nrs);
        chk("t3_ar_cnt",   128'(ar_q.size() - nar), 128'(2));
        chk("t3_ar0_addr", 128'(ar_q[nar].addr),   128'h0FF0);
        chk("t3_ar0_len",  128'(ar_q[nar].len),    128'(0));
        chk("t3_ar1_addr", 128'(ar_q[nar+1].addr), 128'h1000);
        chk("t3_ar1_len",  128'(ar_q[nar+1].len),  128'(1));
        chk("t3_ar_size",  128'(ar_q[nar].size),   128'(4));
        chk("t3_rd_cnt",   128'(rd_q.size() - nrd), 128'(3));
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t3_rd%0d_last", i), 128'(rd_q[nrd+i].last), 128'(i == 2));
            chk($sformatf("t3_rd%0d_data", i), rd_q[nrd+i].data, {4{32'h1000_0000 + 32'(nrd + i)}});
        end
        chk("t3_rsp", 128'(rsp_q[nrs].payload), 128'(0));

        // 128 B read @0x0 with a stalling consumer: two 4-beat bursts
        rd_toggle = 1'b1;
        nar = ar_q.size(); nrd = rd_q.size(); nrs = rsp_q.size();
        send_cmd(1'b0, 32'h0, 32'd128, hs);
        wait_rsp(nrs);
        rd_toggle = 1'b0;
        chk("t4_ar_cnt",   128'(ar_q.size() - nar), 128'(2));
        chk("t4_ar0_addr", 128'(ar_q[nar].addr),   128'h0);
        chk("t4_ar0_len",  128'(ar_q[nar].len),    128'(3));
        chk("t4_ar1_addr", 128'(ar_q[nar+1].addr), 128'h40);
        chk("t4_ar1_len",  128'(ar_q[nar+1].len),  128'(3));
        chk("t4_rd_cnt",   128'(rd_q.size() - nrd), 128'(8));
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t4_rd%0d_data", i), rd_q[nrd+i].data, {4{32'h1000_0000 + 32'(nrd + i)}});
            chk($sformatf("t4_rd%0d_last", i), 128'(rd_q[nrd+i].last), 128'(i == 7));
        end

        // 128 B write @0x3000, first B returns SLVERR
        naw = aw_q.size(); nw = w_q.size(); nrs = rsp_q.size(); nb = b_total;
        err_idx = b_total;
        send_cmd(1'b1, 32'h3000, 32'd128, hs);
        wait_rsp(nrs);
        err_idx = -1;
        chk("t5_aw_cnt",   128'(aw_q.size() - naw), 128'(2));
        chk("t5_aw0_addr", 128'(aw_q[naw].addr),   128'h3000);
        chk("t5_aw1_addr", 128'(aw_q[naw+1].addr), 128'h3040);
        chk("t5_w_cnt",    128'(w_q.size() - nw),  128'(8));
        chk("t5_w3_last",  128'(w_q[nw+3].last),   128'(1));
        chk("t5_w7_last",  128'(w_q[nw+7].last),   128'(1));
        chk("t5_w7_strb",  128'(w_q[nw+7].strb),   128'hFFFF);
        chk("t5_b_cnt",    128'(b_total - nb),     128'(2));
        chk("t5_rsp",      128'(rsp_q[nrs].payload), 128'(2));

        // zero-length command: response next cycle, no bus activity
        naw = aw_q.size(); nar = ar_q.size(); nrs = rsp_q.size(); vc = valid_cnt;
        send_cmd(1'b0, 32'h100, 32'd0, hs);
        wait_rsp(nrs);
        chk("t6_rsp_cyc",   128'(rsp_q[nrs].cyc), 128'(hs + 1));
        chk("t6_rsp",       128'(rsp_q[nrs].payload), 128'(0));
        chk("t6_no_valid",  128'(valid_cnt - vc), 128'(0));
        chk("t6_no_ax",     128'((aw_q.size() - naw) + (ar_q.size() - nar)), 128'(0));

        // reset asserted in the middle of a write data phase
        nw = w_q.size(); nrs = rsp_q.size();
        send_cmd(1'b1, 32'h4000, 32'd64, hs);
        t = 0;
        while (w_q.size() < nw + 2 && t < 100) begin
            @(negedge clk); #2; t++;
        end
        @(negedge clk);
        #3;
        chk("t7_w_valid_pre", 128'(axi.w_valid), 128'(1));
        reset = 1'b0;
        #1;
        chk("t7_aw_valid",    128'(axi.aw_valid), 128'(0));
        chk("t7_w_valid",     128'(axi.w_valid),  128'(0));
        chk("t7_ar_valid",    128'(axi.ar_valid), 128'(0));
        chk("t7_cmd_ready",   128'(cmd_ready),    128'(0));
        chk("t7_rsp_valid",   128'(rsp_valid),    128'(0));
        chk("t7_rdata_valid", 128'(rdata_valid),  128'(0));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("t7_no_rsp", 128'(rsp_q.size() - nrs), 128'(0));

        // 16 B write after reset completes normally
        naw = aw_q.size(); nw = w_q.size(); nrs = rsp_q.size();
        send_cmd(1'b1, 32'h5000, 32'd16, hs);
        wait_rsp(nrs);
        chk("t8_aw_cnt",  128'(aw_q.size() - naw), 128'(1));
        chk("t8_aw_addr", 128'(aw_q[naw].addr), 128'h5000);
        chk("t8_aw_len",  128'(aw_q[naw].len),  128'(0));
        chk("t8_w_cnt",   128'(w_q.size() - nw), 128'(1));
        chk("t8_w_strb",  128'(w_q[nw].strb),   128'hFFFF);
        chk("t8_w_last",  128'(w_q[nw].last),   128'(1));
        chk("t8_rsp",     128'(rsp_q[nrs].payload), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/axi4_burst_master.md
Name: axi4_burst_master

Overview:
Parametrised successor to the fixed 128-bit TCP-driven AXI4 master. Converts byte-sized read/write commands from the DPI tcpBus side into legal AXI4 INCR bursts. Splits commands at MAX_BURST_LEN and at BOUNDARY crossings, and generates partial last-beat strobes. Returns one aggregated response per command. Sits between the DPI socket server wrapper and the DUT AXI4 slave port.

Parameters:
DATA_WIDTH, 128, AXI data width in bits; 32/64/128/256/512.
ADDR_WIDTH, 32, AXI address width.
MAX_BURST_LEN, 256, maximum beats per AXI burst; 1..256.
BOUNDARY, 4096, burst must not cross this byte boundary; power of two, at least DATA_WIDTH/8*MAX_BURST_LEN is not required.

Ports:
clk  in  1  clock.
reset  in  1  asynchronous, active-low reset.
cmd_valid / cmd_ready  in/out  1  command handshake.
cmd_write  in  1  1 = write, 0 = read.
cmd_addr  in  ADDR_WIDTH  start byte address; must be DATA_WIDTH/8 aligned.
cmd_size  in  32  transfer length in bytes.
wdata_valid / wdata_ready  in/out  1  write data stream.
wdata_payload_fragment  in  DATA_WIDTH  write beat; wdata_payload_last in 1, ignored (block computes last).
rdata_valid / rdata_ready  out/in  1  read data stream.
rdata_payload_fragment  out  DATA_WIDTH  read beat; rdata_payload_last out 1, final beat of the command.
rsp_valid  out  1  one-cycle response pulse.
rsp_payload  out  2  aggregated AXI resp.
masterAxi_aw_*, w_*, b_*, ar_*, r_*  AXI4 master channels as in the existing master: valid/ready, addr, len[8], size[3], burst[2], data, strb[DATA_WIDTH/8], last, resp.

Behaviour:
- Reset (asynchronous assert): all valids, cmd_ready, rsp_valid and rdata_valid = 0, rsp_payload = 0, and state = IDLE. Release is synchronous to clk.
- FSM states: IDLE, AW, W, B, AR, R, RSP.
  - IDLE: cmd_ready = 1. On acceptance, latch addr, beats = ceil(size/BYTES) and last-beat byte count size mod BYTES, then go to AW or AR.
  - A zero-size command goes to RSP with OKAY and produces no AXI traffic.
- Per burst: len = min(remaining beats, MAX_BURST_LEN, (BOUNDARY - addr mod BOUNDARY)/BYTES).
  - Drive AxLEN = len-1, AxSIZE = log2(BYTES), AxBURST = 2'b01.
  - After each burst: addr += len*BYTES and remaining -= len.
- Only one burst is outstanding at a time.
  - Write path: AW → W (len beats) → B. Back to AW while remaining > 0, else RSP.
  - Read path: AR → R (len beats). Back to AR while remaining > 0, else RSP.
- AW/AR/W valid and payload are held stable until ready; valid never drops without a handshake.
- W state:
  - masterAxi_w_valid = wdata_valid, wdata_ready = masterAxi_w_ready (combinational pass-through).
  - w_last asserts on the final beat of each burst.
  - strb is all ones, except the final beat of the command: low (size mod BYTES) bytes set, or all ones if the remainder is 0.
- R state:
  - rdata_valid = r_valid, r_ready = rdata_ready.
  - rdata_payload_last asserts only on the final beat of the command, not on per-burst r_last.
- b_ready = 1 in B state only.
- Response aggregation: resp_acc resets to 0 per command. On every B, and every R beat, resp_acc = max(resp_acc, resp).
- RSP: rsp_valid = 1 for exactly one cycle with rsp_payload = resp_acc, then IDLE. cmd_ready is 0 during RSP.
- An error response never aborts the command; all remaining bursts are still issued.
- Reset mid-burst: immediate return to IDLE. No handshake completion is guaranteed; the bench re-initialises the slave.

Test Plan:
- DATA_WIDTH=128, write 64 B @0x1000 → one AW addr 0x1000 len 3 size 4 burst 1; 4 W beats strb 0xFFFF, last on beat 4; rsp OKAY.
- Write 40 B @0x2000 → AW len 2; beat 3 strb 0x00FF with last; rsp pulse 1 cycle.
- Read 48 B @0x0FF0 → AR 0x0FF0 len 0, then AR 0x1000 len 1; rdata_payload_last only on 3rd beat despite r_last on beats 1 and 3.
- MAX_BURST_LEN=4, read 128 B @0x0 → ARs at 0x0 and 0x40, both len 3; rdata_ready toggling every cycle → no lost or duplicated beats.
- Write 2 bursts, first B resp SLVERR, second OKAY → second AW still issued; rsp_payload = 2. Size 0 command → rsp next cycle, no AXI valid.
- Assert reset mid-W with w_valid high → all valids 0 in the same cycle (asynchronous); after release a new 16 B write completes normally.
